// File: rtl/sdram_req_arb.sv
// Ring-buffer burst arbiter between an upstream write FIFO, an SDRAM controller and a downstream read FIFO.
// Optional macro SDRAM_ARB_RR_EN selects round-robin arbitration on write/read ties (default: write priority).
module sdram_req_arb #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              sdram_busy,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    input  logic [8:0]        burst_len,
    input  logic [9:0]        wrfifo_level,
    input  logic [9:0]        rdfifo_space,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [8:0]        sdwr_byte,
    output logic [8:0]        sdrd_byte,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wrfifo_rd_en,
    output logic              rdfifo_wr_en,
    output logic [ADDR_W:0]   fill,
    output logic              err
);
    localparam int unsigned FILL_W = ADDR_W + 1;
    localparam int unsigned EW     = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_WREQ, S_WBURST, S_RREQ, S_RBURST, S_WAITIDLE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [8:0]          r_len, w_len_nxt;
    logic [8:0]          r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt, r_rd_ptr, w_rd_ptr_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt, r_rd_addr, w_rd_addr_nxt;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt;
    logic                r_err, w_err_nxt;
    logic                r_wr_req, w_wr_req_nxt, r_rd_req, w_rd_req_nxt;
    logic [8:0]          r_sdwr_byte, w_sdwr_byte_nxt, r_sdrd_byte, w_sdrd_byte_nxt;
    logic                w_start, w_wr_ok, w_rd_ok, w_grant_wr, w_grant_rd;
    logic                w_wr_done, w_rd_done;
    logic [8:0]          w_cnt_inc;

    // Advance a ring pointer by one burst, wrapping at the region size.
    function automatic logic [ADDR_W-1:0] f_adv(input logic [ADDR_W-1:0] p, input logic [8:0] l);
        logic [FILL_W-1:0] s;
        s = FILL_W'(p) + FILL_W'(l);
        if (s >= FILL_W'(DEPTH_WORDS))
            s = s - FILL_W'(DEPTH_WORDS);
        return s[ADDR_W-1:0];
    endfunction

    assign w_start   = sdram_init_done && !sdram_busy && (burst_len != 9'd0);
    assign w_wr_ok   = (wrfifo_level >= 10'(burst_len)) &&
                       ((EW'(r_fill) + EW'(burst_len)) <= EW'(DEPTH_WORDS));
    assign w_rd_ok   = (EW'(r_fill) >= EW'(burst_len)) && (rdfifo_space >= 10'(burst_len));
    assign w_cnt_inc = r_cnt + 9'd1;

`ifdef SDRAM_ARB_RR_EN
    logic r_last_wr, w_last_wr_nxt;
    // On a tie, grant the direction that did not win last time.
    assign w_grant_wr = w_wr_ok && (!w_rd_ok || !r_last_wr);
`else
    assign w_grant_wr = w_wr_ok;
`endif
    assign w_grant_rd = w_rd_ok && !w_grant_wr;

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_addr_nxt   = r_wr_addr;
        w_rd_addr_nxt   = r_rd_addr;
        w_fill_nxt      = r_fill;
        w_err_nxt       = r_err;
        w_wr_req_nxt    = r_wr_req;
        w_rd_req_nxt    = r_rd_req;
        w_sdwr_byte_nxt = r_sdwr_byte;
        w_sdrd_byte_nxt = r_sdrd_byte;
        w_wr_done       = 1'b0;
        w_rd_done       = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        w_last_wr_nxt   = r_last_wr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_len_nxt = burst_len;
                    if (w_grant_wr) begin
                        w_state_nxt     = S_WREQ;
                        w_wr_req_nxt    = 1'b1;
                        w_sdwr_byte_nxt = burst_len;
`ifdef SDRAM_ARB_RR_EN
                        w_last_wr_nxt   = 1'b1;
`endif
                    end else if (w_grant_rd) begin
                        w_state_nxt     = S_RREQ;
                        w_rd_req_nxt    = 1'b1;
                        w_sdrd_byte_nxt = burst_len;
`ifdef SDRAM_ARB_RR_EN
                        w_last_wr_nxt   = 1'b0;
`endif
                    end
                end
            end
            S_WREQ: begin
                if (sdram_wr_ack) begin
                    w_wr_req_nxt = 1'b0;
                    w_cnt_nxt    = 9'd1;
                    if (r_len == 9'd1) w_wr_done = 1'b1;
                    else               w_state_nxt = S_WBURST;
                end
            end
            S_WBURST: begin
                if (sdram_wr_ack && (w_cnt_inc == r_len)) begin
                    w_wr_done = 1'b1;
                end else if (!sdram_busy) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 9'd0;
                end else if (sdram_wr_ack) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RREQ: begin
                if (sdram_rd_ack) begin
                    w_rd_req_nxt = 1'b0;
                    w_cnt_nxt    = 9'd1;
                    if (r_len == 9'd1) w_rd_done = 1'b1;
                    else               w_state_nxt = S_RBURST;
                end
            end
            S_RBURST: begin
                if (sdram_rd_ack && (w_cnt_inc == r_len)) begin
                    w_rd_done = 1'b1;
                end else if (!sdram_busy) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 9'd0;
                end else if (sdram_rd_ack) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAITIDLE: begin
                if (!sdram_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Burst completion: commit pointer and fill together.
        if (w_wr_done) begin
            w_state_nxt   = S_WAITIDLE;
            w_cnt_nxt     = 9'd0;
            w_fill_nxt    = r_fill + FILL_W'(r_len);
            w_wr_ptr_nxt  = f_adv(r_wr_ptr, r_len);
            w_wr_addr_nxt = ADDR_W'(BASE_ADDR) + f_adv(r_wr_ptr, r_len);
        end
        if (w_rd_done) begin
            w_state_nxt   = S_WAITIDLE;
            w_cnt_nxt     = 9'd0;
            w_fill_nxt    = r_fill - FILL_W'(r_len);
            w_rd_ptr_nxt  = f_adv(r_rd_ptr, r_len);
            w_rd_addr_nxt = ADDR_W'(BASE_ADDR) + f_adv(r_rd_ptr, r_len);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= 9'd0;
            r_cnt       <= 9'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_addr   <= ADDR_W'(BASE_ADDR);
            r_rd_addr   <= ADDR_W'(BASE_ADDR);
            r_fill      <= '0;
            r_err       <= 1'b0;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_sdwr_byte <= 9'd0;
            r_sdrd_byte <= 9'd0;
`ifdef SDRAM_ARB_RR_EN
            r_last_wr   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_fill      <= w_fill_nxt;
            r_err       <= w_err_nxt;
            r_wr_req    <= w_wr_req_nxt;
            r_rd_req    <= w_rd_req_nxt;
            r_sdwr_byte <= w_sdwr_byte_nxt;
            r_sdrd_byte <= w_sdrd_byte_nxt;
`ifdef SDRAM_ARB_RR_EN
            r_last_wr   <= w_last_wr_nxt;
`endif
        end
    end

    assign sdram_wr_req = r_wr_req;
    assign sdram_rd_req = r_rd_req;
    assign sdwr_byte    = r_sdwr_byte;
    assign sdrd_byte    = r_sdrd_byte;
    assign wr_addr      = r_wr_addr;
    assign rd_addr      = r_rd_addr;
    assign fill         = r_fill;
    assign err          = r_err;
    // FIFO strobes follow the acks combinationally, but only inside a burst.
    assign wrfifo_rd_en = sdram_wr_ack && ((r_state == S_WREQ) || (r_state == S_WBURST));
    assign rdfifo_wr_en = sdram_rd_ack && ((r_state == S_RREQ) || (r_state == S_RBURST));

endmodule

// File: doc/sdram_req_arb.md
SDRAM_REQ_ARB -- requirements
Module: sdram_req_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, the SDRAM word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, the first word address of the ring region.
REQ-003 SHALL have parameter DEPTH_WORDS, default 4096, the ring region size in words; it SHALL be a multiple of every burst_len used.
REQ-004 clk  input  1  system clock, same domain as the SDRAM controller.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sdram_init_done  input  1  controller initialisation complete.
REQ-007 sdram_busy  input  1  controller not in idle.
REQ-008 sdram_wr_ack  input  1  controller consumes one write word this cycle.
REQ-009 sdram_rd_ack  input  1  controller delivers one read word this cycle.
REQ-010 burst_len  input  9  words per burst (1-256); 0 means no bursts are issued.
REQ-011 wrfifo_level  input  10  words available in the upstream write FIFO.
REQ-012 rdfifo_space  input  10  free words in the downstream read FIFO.
REQ-013 sdram_wr_req / sdram_rd_req  output  1 each  request to the controller.
REQ-014 sdwr_byte / sdrd_byte  output  9 each  burst length presented with the request.
REQ-015 wr_addr / rd_addr  output  ADDR_W each  burst start address, BASE_ADDR + pointer.
REQ-016 wrfifo_rd_en  output  1  equals sdram_wr_ack while in a write burst.
REQ-017 rdfifo_wr_en  output  1  equals sdram_rd_ack while in a read burst.
REQ-018 fill  output  ADDR_W+1  words held in the ring region.
REQ-019 err  output  1  sticky burst-length mismatch flag.

Function
REQ-020 SHALL implement the states IDLE, WREQ, WBURST, RREQ, RBURST and WAITIDLE.
REQ-021 In IDLE, when sdram_init_done=1, sdram_busy=0 and burst_len!=0, the block SHALL latch burst_len into len_r and make an eligibility decision.
- Write is eligible when wrfifo_level>=len_r and fill+len_r<=DEPTH_WORDS.
- Read is eligible when fill>=len_r and rdfifo_space>=len_r.
REQ-022 When both are eligible, the block SHALL give priority to write, except as modified by REQ-037.
REQ-023 On entering WREQ/RREQ, the block SHALL assert the corresponding req the next cycle, with sdwr_byte/sdrd_byte=len_r and the address stable.
REQ-024 The block SHALL hold req high until the first ack cycle and deassert it the cycle after that ack.
- A refresh inserted by the controller SHALL NOT drop req.
REQ-025 WREQ SHALL move to WBURST on the first sdram_wr_ack; RREQ SHALL move to RBURST on the first sdram_rd_ack.
REQ-026 In WBURST/RBURST, the block SHALL count ack cycles including the first; when the count reaches len_r it SHALL enter WAITIDLE.
REQ-027 WAITIDLE SHALL return to IDLE on the first cycle with sdram_busy=0.
- The earliest new request is the cycle after that.
REQ-028 On burst completion, the active pointer SHALL advance by len_r.
- If the result is >=DEPTH_WORDS, DEPTH_WORDS SHALL be subtracted (wrap).
REQ-029 fill SHALL change only on burst completion: +len_r for a write, -len_r for a read.
- fill SHALL never exceed DEPTH_WORDS or go below 0.
REQ-030 If sdram_busy falls in WBURST/RBURST before the count reaches len_r, the block SHALL set err=1 and go to IDLE, leaving pointers and fill unchanged.
REQ-031 Acks received in IDLE or WAITIDLE SHALL be ignored, and the corresponding *_en output SHALL stay 0.
REQ-032 A change of burst_len mid-burst SHALL have no effect until the next IDLE decision.

Reset
REQ-033 On rst_n=0, the block SHALL force state IDLE, both reqs 0, sdwr_byte/sdrd_byte 0, both pointers 0 (addr=BASE_ADDR), fill 0, err 0, and the counter 0, immediately and asynchronously.
REQ-034 A reset mid-burst SHALL discard the burst without any pointer or fill update.
REQ-035 err SHALL clear only by reset.

Configuration
REQ-036 Macro SDRAM_ARB_RR_EN SHALL select round-robin arbitration.
REQ-037 With SDRAM_ARB_RR_EN defined, when both write and read are eligible, the block SHALL grant the direction not granted last (first tie after reset: write); the last-grant flag SHALL reset to read.
REQ-038 Without SDRAM_ARB_RR_EN, write SHALL have fixed priority and no last-grant register SHALL exist.

Verification
REQ-039 burst_len=8, wrfifo_level=8, fill=0 -> wr_req high until first wr_ack, then 8 wrfifo_rd_en pulses; fill=8, wr_addr=BASE+8.
REQ-040 fill=8, rdfifo_space=100, wrfifo_level=0 -> rd_req, 8 rdfifo_wr_en pulses, fill=0, rd_addr=BASE+8.
REQ-041 DEPTH_WORDS=16, burst_len=8, three full write+read cycles -> pointer sequence 8, 0, 8; fill ends at 0.
- With fill=16: no wr_req even with wrfifo_level=512.
REQ-042 Write and read both eligible for 4 consecutive decisions -> grants W,W,W,W without macro; W,R,W,R with SDRAM_ARB_RR_EN.
REQ-043 sdram_busy drops after 3 of 8 wr_acks -> err=1, IDLE, fill and wr_addr unchanged.
- Separately: a refresh before the first ack keeps wr_req high throughout the refresh.
REQ-044 rst_n pulsed low mid RBURST -> all outputs at reset values within the same cycle; no fill change.
